// File: rtl/fifo_drain_pkg.sv
// Shared constants and state encoding for the FIFO drain serializer.
package fifo_drain_pkg;

  localparam int unsigned DefWordW = 48;
  localparam int unsigned DefBeatW = 16;
  localparam int unsigned DefCntW  = 16;

  typedef logic [1:0] state_t;

  localparam state_t StIdle  = 2'd0;
  localparam state_t StFetch = 2'd1;
  localparam state_t StSend  = 2'd2;

  // A one-beat configuration still needs a 1-bit index register.
  function automatic int unsigned beat_idx_width(input int unsigned beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/fifo_drain_serializer.sv
// Pops 48-bit words from the FIFO and streams them LSB slice first as narrow beats.
// Optional FIFO_DRAIN_LAST_EN adds an out_last marker on the final beat of each word.
module fifo_drain_serializer
  import fifo_drain_pkg::*;
#(
  parameter int unsigned WORD_W = DefWordW,
  parameter int unsigned BEAT_W = DefBeatW,
  parameter int unsigned CNT_W  = DefCntW
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fifo_empty,
  input  logic [WORD_W-1:0] fifo_data_out,
  output logic              fifo_read_enable,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BEAT_W-1:0] out_data,
`ifdef FIFO_DRAIN_LAST_EN
  output logic              out_last,
`endif
  output logic              busy,
  output logic [CNT_W-1:0]  word_count
);

  localparam int unsigned BEATS  = WORD_W / BEAT_W;
  localparam int unsigned BIDX_W = beat_idx_width(BEATS);
  localparam logic [BIDX_W-1:0] LastIdx = BIDX_W'(BEATS - 1);

  if ((WORD_W % BEAT_W) != 0) begin : g_bad_width
    $error("WORD_W must be an integer multiple of BEAT_W");
  end

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   shift_q, shift_d;
  logic [WORD_W-1:0]   shifted;
  logic [BEAT_W-1:0]   out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic [BIDX_W-1:0]   beat_idx_q, beat_idx_d;
  logic [CNT_W-1:0]    word_count_q, word_count_d;

  assign shifted = shift_q >> BEAT_W;

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    beat_idx_d   = beat_idx_q;
    word_count_d = word_count_q;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) state_d = StFetch;
      end
      StFetch: begin
        // FIFO read data is registered, so it is valid in the cycle after the read.
        shift_d     = fifo_data_out;
        out_data_d  = fifo_data_out[BEAT_W-1:0];
        out_valid_d = 1'b1;
        beat_idx_d  = '0;
        state_d     = StSend;
      end
      StSend: begin
        if (out_valid_q && out_ready) begin
          if (beat_idx_q != LastIdx) begin
            shift_d    = shifted;
            out_data_d = shifted[BEAT_W-1:0];
            beat_idx_d = beat_idx_q + BIDX_W'(1);
          end else begin
            out_valid_d  = 1'b0;
            word_count_d = word_count_q + CNT_W'(1);
            state_d      = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      shift_q      <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      beat_idx_q   <= '0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      beat_idx_q   <= beat_idx_d;
      word_count_q <= word_count_d;
    end
  end

  // Reads only leave IDLE, which keeps them at least BEATS+1 cycles apart.
  assign fifo_read_enable = (state_q == StIdle) && !fifo_empty;
  assign busy             = (state_q != StIdle);
  assign out_valid        = out_valid_q;
  assign out_data         = out_data_q;
  assign word_count       = word_count_q;

`ifdef FIFO_DRAIN_LAST_EN
  assign out_last = out_valid_q && (beat_idx_q == LastIdx);
`endif

  property p_stall_stable;
    @(posedge clk) disable iff (!reset_n)
      (out_valid && !out_ready) |=> (out_valid && $stable(out_data));
  endproperty
  a_stall_stable: assert property (p_stall_stable);

  property p_no_back_to_back_read;
    @(posedge clk) disable iff (!reset_n)
      fifo_read_enable |=> !fifo_read_enable;
  endproperty
  a_no_back_to_back_read: assert property (p_no_back_to_back_read);

endmodule

// File: tb/tb_fifo_drain_serializer.sv
// Randomized self-checking bench: a queue-based FIFO model feeds the DUT and a
// beat/word scoreboard checks the stream, counter, stalls and read spacing.
module tb_fifo_drain_serializer;

  localparam int unsigned WORD_W = 48;
  localparam int unsigned BEAT_W = 16;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned BEATS  = WORD_W / BEAT_W;
  localparam int unsigned FDEPTH = 4;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              fifo_empty = 1'b1;
  logic [WORD_W-1:0] fifo_data_out = '0;
  logic              fifo_read_enable;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [BEAT_W-1:0] out_data;
  logic              busy;
  logic [CNT_W-1:0]  word_count;
`ifdef FIFO_DRAIN_LAST_EN
  logic              out_last;
`endif

  fifo_drain_serializer #(
    .WORD_W(WORD_W),
    .BEAT_W(BEAT_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .fifo_empty      (fifo_empty),
    .fifo_data_out   (fifo_data_out),
    .fifo_read_enable(fifo_read_enable),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
`ifdef FIFO_DRAIN_LAST_EN
    .out_last        (out_last),
`endif
    .busy            (busy),
    .word_count      (word_count)
  );

  always #5 clk = ~clk;

  int nchecks = 0;
  int nfail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchecks++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // FIFO content and expected beat stream.
  logic [WORD_W-1:0] fq[$];
  logic [BEAT_W-1:0] exp_beats[$];

  always @(posedge clk) begin
    if (fifo_read_enable && fq.size() != 0) begin
      fifo_data_out <= fq.pop_front();
      fifo_empty    <= (fq.size() == 0);
    end
  end

  // Scoreboard state.
  int          cyc = 0;
  int          reads = 0;
  int          hs_total = 0;
  int          beat_in_word = 0;
  int          model_wc = 0;
  int          last_rd_cyc = 0;
  int          first_hs_cyc = 0;
  int          last_hs_cyc = 0;
  logic        prev_rd = 1'b0;
  logic        prev_stall = 1'b0;
  logic [BEAT_W-1:0] prev_data = '0;

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_rd    = 1'b0;
      prev_stall = 1'b0;
    end else begin
      cyc++;
      check("word_count", word_count, model_wc);
      if (prev_stall) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, prev_data);
      end
`ifdef FIFO_DRAIN_LAST_EN
      check("out_last", out_last, out_valid && (beat_in_word == BEATS - 1));
`endif
      if (fifo_read_enable) begin
        check("read_gap", prev_rd, 0);
        reads++;
        last_rd_cyc = cyc;
      end
      prev_rd = fifo_read_enable;
      if (out_valid && out_ready) begin
        if (exp_beats.size() == 0) check("beat_pending", 0, 1);
        else check("beat_data", out_data, exp_beats.pop_front());
        hs_total++;
        if (beat_in_word == 0) first_hs_cyc = cyc;
        if (beat_in_word == BEATS - 1) last_hs_cyc = cyc;
        beat_in_word++;
        if (beat_in_word == BEATS) begin
          beat_in_word = 0;
          model_wc = (model_wc + 1) % (1 << CNT_W);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [WORD_W-1:0] w);
    for (int i = 0; i < 200 && fq.size() >= FDEPTH; i++) step();
    if (fq.size() >= FDEPTH) check("push_timeout", fq.size(), FDEPTH - 1);
    fq.push_back(w);
    fifo_empty = 1'b0;
    for (int b = 0; b < BEATS; b++) exp_beats.push_back(w[b*BEAT_W +: BEAT_W]);
  endtask

  task automatic wait_drain();
    int i;
    for (i = 0; i < 500; i++) begin
      if (exp_beats.size() == 0 && fq.size() == 0 && !busy) break;
      step();
    end
    if (i == 500) check("drain_timeout", exp_beats.size(), 0);
    step();
  endtask

  task automatic wait_beats(input int target);
    int i;
    for (i = 0; i < 200; i++) begin
      step();
      if (hs_total >= target) break;
    end
    if (hs_total < target) check("beat_timeout", hs_total, target);
  endtask

  logic [63:0] rnd;
  int          base_reads;
  int          base_hs;
  int          pushed;

  initial begin
    // Reset state.
    #3;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_count", word_count, 0);
    check("rst_busy", busy, 0);
    check("rst_rd", fifo_read_enable, 0);
    step();
    reset_n = 1'b1;
    step();

    // Single word, ready held high.
    out_ready  = 1'b1;
    base_reads = reads;
    push_word(48'h1111_2222_3333);
    wait_drain();
    check("single_reads", reads - base_reads, 1);
    check("single_count", word_count, 1);
    check("single_latency", first_hs_cyc - last_rd_cyc, 2);
    check("single_consec", last_hs_cyc - first_hs_cyc, BEATS - 1);

    // Backpressure on the second beat.
    base_hs = hs_total;
    push_word(48'h1111_2222_3333);
    wait_beats(base_hs + 1);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_valid", out_valid, 1);
      check("bp_data", out_data, 16'h2222);
      check("bp_count", word_count, 1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_drain();
    check("bp_count_done", word_count, 2);

    // Four words queued at once.
    base_reads = reads;
    base_hs    = hs_total;
    for (int i = 0; i < 4; i++) begin
      rnd = {$urandom(), $urandom()};
      push_word(rnd[WORD_W-1:0]);
    end
    wait_drain();
    repeat (5) step();
    check("four_reads", reads - base_reads, 4);
    check("four_beats", hs_total - base_hs, 4 * BEATS);
    check("four_count", word_count, 6);
    check("four_idle", busy, 0);

    // Random traffic and backpressure: ten more words wraps the 4-bit counter.
    pushed = 0;
    for (int i = 0; i < 2000 && pushed < 10; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (fq.size() < FDEPTH && $urandom_range(0, 2) == 0) begin
        rnd = {$urandom(), $urandom()};
        push_word(rnd[WORD_W-1:0]);
        pushed++;
      end
      step();
    end
    out_ready = 1'b1;
    wait_drain();
    check("wrap_count", word_count, 0);

    // Reset in the middle of a word.
    base_hs = hs_total;
    push_word(48'hAAAA_BBBB_CCCC);
    wait_beats(base_hs + 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_count", word_count, 0);
    check("mid_rst_busy", busy, 0);
    exp_beats.delete();
    beat_in_word = 0;
    model_wc     = 0;
    step();
    reset_n    = 1'b1;
    base_hs    = hs_total;
    base_reads = reads;
    repeat (20) step();
    check("post_rst_beats", hs_total - base_hs, 0);
    check("post_rst_reads", reads - base_reads, 0);
    check("post_rst_valid", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
    $finish;
  end

endmodule
